credit_sender: RTL and testbench
================================

Name: credit_sender

Overview:
- Upstream neighbour of the credit receiver: the sender side of a credit-based, valid-only link.
- Accepts data from a ready/valid producer and forwards it as push_valid/push_data only while it holds credit.
- Gains credit back from the receiver's returned credit pulse; runs the reset handshake with the receiver so neither side loses or duplicates credit.

Parameters:
- DATA_WIDTH, 8, payload width in bits.
- MAX_CREDIT, 15, maximum credits held; counter saturates here.
- COUNTW, $clog2(MAX_CREDIT+1), credit counter width (derived; not overridden).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- push_ready  out  1  producer may transfer this cycle.
- push_valid  in  1  producer data valid.
- push_data  in  DATA_WIDTH  producer payload.
- pop_valid  out  1  payload valid toward receiver.
- pop_data  out  DATA_WIDTH  payload toward receiver.
- pop_credit  in  1  one credit returned by receiver this cycle.
- pop_sender_in_reset  out  1  sender in INIT state.
- pop_receiver_in_reset  in  1  receiver in reset.
- credit_initial  in  COUNTW  credits loaded when leaving INIT; quasi-static.
- credit_withhold  in  COUNTW  credits held back from use; may change any cycle.
- credit_count  out  COUNTW  current credit counter.
- credit_available  out  COUNTW  usable credits.
- credit_overflow  out  1  sticky: credit returned while counter at MAX_CREDIT.

Behaviour:
- States: INIT, ACTIVE. While rst_n=0 (async): state=INIT, credit_count=0, credit_overflow=0.
- Outputs in INIT: pop_sender_in_reset=1, push_ready=0, pop_valid=0. pop_credit is ignored.
- INIT lasts at least one cycle after rst_n deasserts. It stays in INIT while pop_receiver_in_reset=1.
- INIT -> ACTIVE on the edge where pop_receiver_in_reset=0. On that edge credit_count <= min(credit_initial, MAX_CREDIT).
- ACTIVE -> INIT on any edge where pop_receiver_in_reset=1. On that edge credit_count <= 0; credit_overflow is kept.
- credit_available = (credit_count > credit_withhold) ? credit_count - credit_withhold : 0. It is combinational and valid in every state; it is 0 in INIT because the count is 0.
- push_ready = ACTIVE & (credit_available != 0). It never depends on push_valid.
- Transfer xfer = push_valid & push_ready.
- Base build: pop_valid = xfer, pop_data = push_data. Zero latency.
- In ACTIVE, next credit_count = credit_count - xfer + pop_credit, computed in COUNTW+1 bits.
  - Simultaneous xfer and pop_credit: count unchanged.
  - pop_credit with count=MAX_CREDIT and no xfer: count stays at MAX_CREDIT and credit_overflow <= 1, sticky until rst_n.
  - Underflow cannot occur, because xfer requires credit_available >= 1.
- Raising credit_withhold above credit_count stalls the producer without losing credit. Credits returned meanwhile still accumulate.
- pop_data is don't-care when pop_valid=0.

Optional Feature:
- Macro: CREDIT_SENDER_POP_REG_EN.
- Defined:
  - pop_valid and pop_data are registered, giving 1-cycle latency from xfer.
  - Credit is still debited at xfer.
  - The pop register resets to pop_valid=0 on rst_n and clears on entry to INIT. An in-flight beat is dropped on INIT entry.
  - pop_data loads only on xfer.
- Undefined: combinational pass-through as above.

Test Plan:
- Reset handshake: rst_n low, then high with pop_receiver_in_reset=1 for 3 cycles, credit_initial=4 -> pop_sender_in_reset=1 and push_ready=0 throughout. First cycle after release: credit_count=4, push_ready=1.
- Credit exhaustion: credit_initial=3, push_valid held 1 with data 0x11,0x22,0x33,0x44 -> exactly 3 pop_valid beats carrying 0x11..0x33, then push_ready=0 and credit_count=0. One pop_credit pulse -> 0x44 forwarded next cycle.
- Simultaneous: count=2, xfer and pop_credit in the same cycle for 5 cycles -> count stays 2 and every beat is forwarded.
- Withhold: count=5, credit_withhold=5 -> credit_available=0, push_ready=0. Withhold=3 -> credit_available=2, and exactly 2 beats pass.
- Overflow: count=15 (MAX_CREDIT), pop_credit=1, no push -> count stays 15, credit_overflow=1, and it stays 1 after pop_credit drops.
- Receiver reset mid-stream: ACTIVE with count=6, pop_receiver_in_reset pulses 1 -> next cycle state=INIT, count=0, push_ready=0. After release, count=credit_initial. With CREDIT_SENDER_POP_REG_EN, the pending pop_valid is cleared.

Source files
------------

// File: rtl/credit_sender.sv
// credit_sender: sender side of a credit-based valid-only link, including the reset handshake with the receiver.
// Define CREDIT_SENDER_POP_REG_EN to register pop_valid/pop_data (1-cycle latency); otherwise pass-through.
module credit_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_CREDIT = 15,
    localparam int COUNTW = $clog2(MAX_CREDIT + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  push_ready,
    input  logic                  push_valid,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] pop_data,
    input  logic                  pop_credit,
    output logic                  pop_sender_in_reset,
    input  logic                  pop_receiver_in_reset,
    input  logic [COUNTW-1:0]     credit_initial,
    input  logic [COUNTW-1:0]     credit_withhold,
    output logic [COUNTW-1:0]     credit_count,
    output logic [COUNTW-1:0]     credit_available,
    output logic                  credit_overflow
);

    localparam logic [COUNTW:0]   MAX_W = (COUNTW + 1)'(MAX_CREDIT);
    localparam logic [COUNTW-1:0] MAX_C = COUNTW'(MAX_CREDIT);

    typedef enum logic {INIT, ACTIVE} state_t;

    state_t              state, state_nxt;
    logic [COUNTW-1:0]   count_nxt;
    logic                overflow_nxt;
    logic [COUNTW:0]     count_sum;
    logic [COUNTW-1:0]   init_clamped;
    logic                xfer;

    assign credit_available    = (credit_count > credit_withhold) ? credit_count - credit_withhold : '0;
    assign push_ready          = (state == ACTIVE) && (credit_available != '0);
    assign pop_sender_in_reset = (state == INIT);
    assign xfer                = push_valid & push_ready;

    // One extra bit so a return at MAX_CREDIT is visible as a carry rather than wrapping.
    assign count_sum    = {1'b0, credit_count} - (COUNTW + 1)'(xfer) + (COUNTW + 1)'(pop_credit);
    assign init_clamped = ({1'b0, credit_initial} > MAX_W) ? MAX_C : credit_initial;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= INIT;
            credit_count    <= '0;
            credit_overflow <= 1'b0;
        end else begin
            state           <= state_nxt;
            credit_count    <= count_nxt;
            credit_overflow <= overflow_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        count_nxt    = credit_count;
        overflow_nxt = credit_overflow;
        case (state)
            INIT: begin
                if (!pop_receiver_in_reset) begin
                    state_nxt = ACTIVE;
                    count_nxt = init_clamped;
                end
            end
            ACTIVE: begin
                if (pop_receiver_in_reset) begin
                    state_nxt = INIT;
                    count_nxt = '0;
                end else if (count_sum > MAX_W) begin
                    count_nxt    = MAX_C;
                    overflow_nxt = 1'b1;
                end else begin
                    count_nxt = count_sum[COUNTW-1:0];
                end
            end
            default: begin
                state_nxt = INIT;
                count_nxt = '0;
            end
        endcase
    end

`ifdef CREDIT_SENDER_POP_REG_EN
    // Credit is already debited at xfer; a beat caught by INIT entry is dropped, not replayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_valid <= 1'b0;
        end else if (state == ACTIVE && pop_receiver_in_reset) begin
            pop_valid <= 1'b0;
        end else begin
            pop_valid <= xfer;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pop_data <= '0;
        end else if (xfer) begin
            pop_data <= push_data;
        end
    end
`else
    assign pop_valid = xfer;
    assign pop_data  = push_data;
`endif

endmodule

// File: tb/tb_credit_sender.sv
// Directed bench for credit_sender with a scoreboard of forwarded payloads.
module tb_credit_sender;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          push_ready;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          pop_valid;
    logic [DW-1:0] pop_data;
    logic          pop_credit;
    logic          pop_sender_in_reset;
    logic          pop_receiver_in_reset;
    logic [CW-1:0] credit_initial;
    logic [CW-1:0] credit_withhold;
    logic [CW-1:0] credit_count;
    logic [CW-1:0] credit_available;
    logic          credit_overflow;

    int            vectors = 0;
    int            errors = 0;
    int            beats = 0;
    int            b0;
    logic [DW-1:0] sb[$];

    credit_sender #(.DATA_WIDTH(DW), .MAX_CREDIT(15)) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .push_ready            (push_ready),
        .push_valid            (push_valid),
        .push_data             (push_data),
        .pop_valid             (pop_valid),
        .pop_data              (pop_data),
        .pop_credit            (pop_credit),
        .pop_sender_in_reset   (pop_sender_in_reset),
        .pop_receiver_in_reset (pop_receiver_in_reset),
        .credit_initial        (credit_initial),
        .credit_withhold       (credit_withhold),
        .credit_count          (credit_count),
        .credit_available      (credit_available),
        .credit_overflow       (credit_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: expected beats pushed at transfer, compared when the DUT presents them.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
`ifdef CREDIT_SENDER_POP_REG_EN
            if (push_valid && push_ready && !pop_receiver_in_reset) sb.push_back(push_data);
`else
            if (push_valid && push_ready) sb.push_back(push_data);
`endif
            if (pop_valid === 1'b1) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("pop_data", 32'(pop_data), 32'(sb.pop_front()));
                beats++;
            end
        end
    end

    initial begin
        push_valid = 1'b0;
        push_data = '0;
        pop_credit = 1'b0;
        pop_receiver_in_reset = 1'b1;
        credit_initial = 4'd4;
        credit_withhold = 4'd0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(credit_count), 32'd0);
        chk("rst_ovf", 32'(credit_overflow), 32'd0);
        chk("rst_sir", 32'(pop_sender_in_reset), 32'd1);
        chk("rst_ready", 32'(push_ready), 32'd0);
        chk("rst_avail", 32'(credit_available), 32'd0);

        // Handshake: receiver still in reset for 3 cycles
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hs_sir", 32'(pop_sender_in_reset), 32'd1);
            chk("hs_ready", 32'(push_ready), 32'd0);
        end
        pop_receiver_in_reset = 1'b0;
        tick();
        chk("hs_count", 32'(credit_count), 32'd4);
        chk("hs_ready1", 32'(push_ready), 32'd1);
        chk("hs_sir0", 32'(pop_sender_in_reset), 32'd0);

        // Exhaustion with 3 initial credits
        pop_receiver_in_reset = 1'b1;
        tick();
        chk("rr_count0", 32'(credit_count), 32'd0);
        credit_initial = 4'd3;
        pop_receiver_in_reset = 1'b0;
        tick();
        chk("ex_count", 32'(credit_count), 32'd3);
        b0 = beats;
        push_valid = 1'b1;
        push_data = 8'h11; tick();
        push_data = 8'h22; tick();
        push_data = 8'h33; tick();
        push_data = 8'h44;
        chk("ex_ready0", 32'(push_ready), 32'd0);
        chk("ex_count0", 32'(credit_count), 32'd0);
        tick();
        tick();
        chk("ex_beats3", 32'(beats - b0), 32'd3);
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        chk("ex_ready1", 32'(push_ready), 32'd1);
        tick();
        push_valid = 1'b0;
        tick();
        tick();
        chk("ex_beats4", 32'(beats - b0), 32'd4);
        chk("ex_count_end", 32'(credit_count), 32'd0);

        // Simultaneous debit and return
        pop_credit = 1'b1;
        tick();
        tick();
        pop_credit = 1'b0;
        chk("sim_count", 32'(credit_count), 32'd2);
        b0 = beats;
        push_valid = 1'b1;
        pop_credit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_data = 8'(8'hA0 + i);
            tick();
            chk("sim_hold", 32'(credit_count), 32'd2);
        end
        push_valid = 1'b0;
        pop_credit = 1'b0;
        tick();
        tick();
        chk("sim_beats", 32'(beats - b0), 32'd5);

        // Withhold
        pop_credit = 1'b1;
        repeat (3) tick();
        pop_credit = 1'b0;
        chk("wh_count", 32'(credit_count), 32'd5);
        credit_withhold = 4'd5;
        #1;
        chk("wh_avail0", 32'(credit_available), 32'd0);
        chk("wh_ready0", 32'(push_ready), 32'd0);
        b0 = beats;
        push_valid = 1'b1;
        push_data = 8'h55;
        tick();
        tick();
        chk("wh_stall", 32'(credit_count), 32'd5);
        credit_withhold = 4'd3;
        #1;
        chk("wh_avail2", 32'(credit_available), 32'd2);
        tick();
        push_data = 8'h66;
        tick();
        push_data = 8'h77;
        chk("wh_ready_end", 32'(push_ready), 32'd0);
        tick();
        tick();
        push_valid = 1'b0;
        chk("wh_beats", 32'(beats - b0), 32'd2);
        chk("wh_count3", 32'(credit_count), 32'd3);
        pop_credit = 1'b1;
        tick();
        pop_credit = 1'b0;
        chk("wh_accum", 32'(credit_count), 32'd4);
        credit_withhold = 4'd0;

        // Overflow at MAX_CREDIT
        pop_credit = 1'b1;
        repeat (11) tick();
        chk("ov_full", 32'(credit_count), 32'd15);
        chk("ov_not_yet", 32'(credit_overflow), 32'd0);
        tick();
        pop_credit = 1'b0;
        chk("ov_sat", 32'(credit_count), 32'd15);
        chk("ov_set", 32'(credit_overflow), 32'd1);
        tick();
        chk("ov_sticky", 32'(credit_overflow), 32'd1);

        // Receiver reset mid-stream
        pop_receiver_in_reset = 1'b1;
        tick();
        chk("mr_ovf_kept", 32'(credit_overflow), 32'd1);
        credit_initial = 4'd6;
        pop_receiver_in_reset = 1'b0;
        tick();
        chk("mr_count6", 32'(credit_count), 32'd6);
        push_valid = 1'b1;
        push_data = 8'hC1;
        pop_receiver_in_reset = 1'b1;
        tick();
        push_valid = 1'b0;
        chk("mr_sir", 32'(pop_sender_in_reset), 32'd1);
        chk("mr_count0", 32'(credit_count), 32'd0);
        chk("mr_ready0", 32'(push_ready), 32'd0);
        chk("mr_pop0", 32'(pop_valid), 32'd0);
        pop_receiver_in_reset = 1'b0;
        tick();
        chk("mr_reload", 32'(credit_count), 32'd6);
        tick();
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
